kmeans_kn_engine: RTL and testbench

- Parametrised k-means clustering engine: K centroids, 2 dimensions, unsigned data of width DW, streamed from an external 1-cycle-latency data memory.
- Runs complete Lloyd iterations autonomously. Each iteration is assign, accumulate, divide and update, repeated until the centroids stop moving or MAX_ITER is reached.
- Successor to the fixed k2n2 datapath. Adds runtime point count, per-cluster sum and count accumulation, centroid division, and convergence control.

---
 rtl/kmeans_pkg.sv | 32 +++
 rtl/kmeans_seq_div.sv | 71 +++++++
 rtl/kmeans_kn_engine.sv | 270 +++++++++++++++++++++++++++
 tb/tb_kmeans_kn_engine.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/kmeans_pkg.sv
// Shared types, width helpers and pipeline constants for the k-means engine.
package kmeans_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DIVIDE = 3'd4,
    ST_UPDATE = 3'd5,
    ST_FINISH = 3'd6
  } state_e;

  // Cycles from a read strobe to the accumulator write.
  localparam int PIPE_LAT = 5;

  // Per-cluster coordinate sum: holds 2**AW points of the maximum value.
  function automatic int sum_w_f(input int dw, input int aw);
    return dw + aw + 1;
  endfunction

  // Per-cluster point count: 0..2**AW.
  function automatic int cnt_w_f(input int aw);
    return aw + 1;
  endfunction

  // Squared euclidean distance over two dimensions.
  function automatic int dist_w_f(input int dw);
    return 2 * dw + 1;
  endfunction

endpackage

// File: rtl/kmeans_seq_div.sv
// Restoring unsigned divider, one quotient bit per cycle. A result appears
// SUM_W+1 cycles after start; the quotient is truncated to DW bits since a
// cluster mean never exceeds the largest coordinate.
module kmeans_seq_div import kmeans_pkg::*; #(
  parameter int DW = 16,
  parameter int AW = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [sum_w_f(DW, AW)-1:0] dividend,
  input  logic [cnt_w_f(AW)-1:0]     divisor,
  output logic                      busy,
  output logic                      done,
  output logic [DW-1:0]             quotient
);

  localparam int SUM_W  = sum_w_f(DW, AW);
  localparam int CNT_W  = cnt_w_f(AW);
  localparam int STEP_W = $clog2(SUM_W + 1);

  logic              busy_r;
  logic              done_r;
  logic [STEP_W-1:0] step_r;
  logic [SUM_W-1:0]  quo_r;
  logic [CNT_W-1:0]  rem_r;
  logic [CNT_W-1:0]  div_r;
  logic [CNT_W:0]    rem_shift_s;

  assign rem_shift_s = {rem_r, quo_r[SUM_W-1]};

  // Load operands on start, then shift/subtract one bit per cycle and flag completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      step_r <= '0;
      quo_r  <= '0;
      rem_r  <= '0;
      div_r  <= '0;
    end else begin
      done_r <= 1'b0;
      if (!busy_r) begin
        if (start) begin
          busy_r <= 1'b1;
          quo_r  <= dividend;
          rem_r  <= '0;
          div_r  <= divisor;
          step_r <= STEP_W'(SUM_W);
        end
      end else if (step_r != '0) begin
        step_r <= step_r - STEP_W'(1);
        if (rem_shift_s >= {1'b0, div_r}) begin
          rem_r <= CNT_W'(rem_shift_s - {1'b0, div_r});
          quo_r <= {quo_r[SUM_W-2:0], 1'b1};
        end else begin
          rem_r <= CNT_W'(rem_shift_s);
          quo_r <= {quo_r[SUM_W-2:0], 1'b0};
        end
      end else begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign quotient = quo_r[DW-1:0];

endmodule

// File: rtl/kmeans_kn_engine.sv
// K-centroid, 2-D k-means engine: streams points from a 1-cycle memory,
// assigns each to its nearest centroid, accumulates per-cluster sums and
// divides to new means, iterating until stable or MAX_ITER is reached.
module kmeans_kn_engine import kmeans_pkg::*; #(
  parameter int K        = 4,
  parameter int DW       = 16,
  parameter int AW       = 8,
  parameter int MAX_ITER = 16,
  parameter int ITW      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AW:0]       n_points,
  input  logic [K*2*DW-1:0] cent_init,
  output logic              mem_rd_en,
  output logic [AW-1:0]     mem_rd_addr,
  input  logic [DW-1:0]     mem_rd_d0,
  input  logic [DW-1:0]     mem_rd_d1,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic [ITW-1:0]    iterations,
  output logic [K*2*DW-1:0] centroids
);

  localparam int SUM_W  = sum_w_f(DW, AW);
  localparam int CNT_W  = cnt_w_f(AW);
  localparam int DIST_W = dist_w_f(DW);
  localparam int SQ_W   = 2 * DW;
  localparam int KW     = (K > 1) ? $clog2(K) : 1;

  state_e                    state_r, state_next_s;
  logic [K-1:0][1:0][DW-1:0] cent_r, new_cent_r;
  logic [AW:0]               n_points_r;
  logic [AW-1:0]             rd_addr_r;
  logic                      rd_en_r, busy_r, done_r, converged_r;
  logic [ITW-1:0]            iter_r;

  logic [PIPE_LAT-1:0]         vld_r;
  logic [1:0][DW-1:0]          bus_pt_s, pt1_r, pt2_r, pt3_r, pt4_r;
  logic [K-1:0][1:0][DW-1:0]   diff1_r;
  logic [K-1:0][1:0][SQ_W-1:0] sq2_r;
  logic [K-1:0][DIST_W-1:0]    dist3_r;
  logic [DIST_W-1:0]           best_s;
  logic [KW-1:0]               argmin_s, idx4_r;

  logic [K-1:0][1:0][SUM_W-1:0] sum_r;
  logic [K-1:0][CNT_W-1:0]      cnt_r;

  logic [KW-1:0]    div_k_r;
  logic             div_d_r, div_pend_r;
  logic [SUM_W-1:0] sel_sum_s;
  logic [CNT_W-1:0] sel_cnt_s;
  logic [DW-1:0]    sel_old_s, elem_val_s, div_q_s;
  logic             div_launch_s, elem_done_s, last_elem_s, div_busy_s, div_done_s;
  logic             changed_s, last_addr_s, pipe_idle_s;

  function automatic logic [DW-1:0] abs_diff(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  assign bus_pt_s    = {mem_rd_d1, mem_rd_d0};
  assign last_addr_s = ({1'b0, rd_addr_r} == (n_points_r - (AW+1)'(1)));
  assign pipe_idle_s = (vld_r == '0);
  assign changed_s   = (new_cent_r != cent_r);
  assign last_elem_s = (div_k_r == KW'(K - 1)) && div_d_r;
  assign div_launch_s = (state_r == ST_DIVIDE) && !div_pend_r && (sel_cnt_s != '0) && !div_busy_s;
  assign elem_done_s  = (state_r == ST_DIVIDE) && (div_pend_r ? div_done_s : (sel_cnt_s == '0));
  assign elem_val_s   = div_pend_r ? div_q_s : sel_old_s;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:   state_next_s = start ? ST_CLEAR : ST_IDLE;
      ST_CLEAR:  state_next_s = (n_points_r == '0) ? ST_DIVIDE : ST_STREAM;
      ST_STREAM: state_next_s = last_addr_s ? ST_DRAIN : ST_STREAM;
      ST_DRAIN:  state_next_s = pipe_idle_s ? ST_DIVIDE : ST_DRAIN;
      ST_DIVIDE: state_next_s = (elem_done_s && last_elem_s) ? ST_UPDATE : ST_DIVIDE;
      ST_UPDATE: begin
        if (!changed_s) begin
          state_next_s = ST_FINISH;
        end else if ((iter_r + ITW'(1)) == ITW'(MAX_ITER)) begin
          state_next_s = ST_FINISH;
        end else begin
          state_next_s = ST_CLEAR;
        end
      end
      ST_FINISH: state_next_s = ST_IDLE;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // Run control: operand latch, read sequencing, divide bookkeeping and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      cent_r      <= '0;
      new_cent_r  <= '0;
      n_points_r  <= '0;
      rd_addr_r   <= '0;
      rd_en_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      converged_r <= 1'b0;
      iter_r      <= '0;
      div_k_r     <= '0;
      div_d_r     <= 1'b0;
      div_pend_r  <= 1'b0;
    end else begin
      done_r <= (state_next_s == ST_FINISH);
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            cent_r      <= cent_init;
            n_points_r  <= n_points;
            iter_r      <= '0;
            converged_r <= 1'b0;
            busy_r      <= 1'b1;
          end
        end
        ST_CLEAR: begin
          div_k_r    <= '0;
          div_d_r    <= 1'b0;
          div_pend_r <= 1'b0;
          if (n_points_r != '0) begin
            rd_en_r   <= 1'b1;
            rd_addr_r <= '0;
          end
        end
        ST_STREAM: begin
          if (last_addr_s) begin
            rd_en_r <= 1'b0;
          end else begin
            rd_addr_r <= rd_addr_r + AW'(1);
          end
        end
        ST_DIVIDE: begin
          if (div_launch_s) begin
            div_pend_r <= 1'b1;
          end
          if (elem_done_s) begin
            div_pend_r <= 1'b0;
            for (int k = 0; k < K; k++) begin
              for (int d = 0; d < 2; d++) begin
                if ((KW'(k) == div_k_r) && (1'(d) == div_d_r)) begin
                  new_cent_r[k][d] <= elem_val_s;
                end
              end
            end
            if (div_d_r) begin
              div_d_r <= 1'b0;
              div_k_r <= div_k_r + KW'(1);
            end else begin
              div_d_r <= 1'b1;
            end
          end
        end
        ST_UPDATE: begin
          cent_r <= new_cent_r;
          iter_r <= iter_r + ITW'(1);
          if (!changed_s) begin
            converged_r <= 1'b1;
          end
        end
        ST_FINISH: busy_r <= 1'b0;
        default: ;
      endcase
    end
  end

  // Distance pipeline: abs diff, squares, sum, argmin; a valid bit rides along.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r   <= '0;
      pt1_r   <= '0;
      pt2_r   <= '0;
      pt3_r   <= '0;
      pt4_r   <= '0;
      diff1_r <= '0;
      sq2_r   <= '0;
      dist3_r <= '0;
      idx4_r  <= '0;
    end else begin
      vld_r <= {vld_r[PIPE_LAT-2:0], rd_en_r};
      pt1_r <= bus_pt_s;
      pt2_r <= pt1_r;
      pt3_r <= pt2_r;
      pt4_r <= pt3_r;
      for (int k = 0; k < K; k++) begin
        for (int d = 0; d < 2; d++) begin
          diff1_r[k][d] <= abs_diff(bus_pt_s[d], cent_r[k][d]);
          sq2_r[k][d]   <= SQ_W'(diff1_r[k][d]) * SQ_W'(diff1_r[k][d]);
        end
        dist3_r[k] <= DIST_W'(sq2_r[k][0]) + DIST_W'(sq2_r[k][1]);
      end
      idx4_r <= argmin_s;
    end
  end

  // Nearest centroid; strict less-than keeps ties on the lowest index.
  always_comb begin
    best_s   = dist3_r[0];
    argmin_s = '0;
    for (int k = 1; k < K; k++) begin
      argmin_s = (dist3_r[k] < best_s) ? KW'(k) : argmin_s;
      best_s   = (dist3_r[k] < best_s) ? dist3_r[k] : best_s;
    end
  end

  // Per-cluster sums and counts, cleared at the start of each iteration.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_r <= '0;
      cnt_r <= '0;
    end else if (state_r == ST_CLEAR) begin
      sum_r <= '0;
      cnt_r <= '0;
    end else if (vld_r[PIPE_LAT-1]) begin
      for (int k = 0; k < K; k++) begin
        if (idx4_r == KW'(k)) begin
          sum_r[k][0] <= sum_r[k][0] + SUM_W'(pt4_r[0]);
          sum_r[k][1] <= sum_r[k][1] + SUM_W'(pt4_r[1]);
          cnt_r[k]    <= cnt_r[k] + CNT_W'(1);
        end
      end
    end
  end

  // Operand select for the centroid/dimension currently being divided.
  always_comb begin
    sel_sum_s = '0;
    sel_cnt_s = '0;
    sel_old_s = '0;
    for (int k = 0; k < K; k++) begin
      sel_sum_s = (KW'(k) == div_k_r) ? sum_r[k][div_d_r]  : sel_sum_s;
      sel_cnt_s = (KW'(k) == div_k_r) ? cnt_r[k]           : sel_cnt_s;
      sel_old_s = (KW'(k) == div_k_r) ? cent_r[k][div_d_r] : sel_old_s;
    end
  end

  kmeans_seq_div #(.DW(DW), .AW(AW)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_launch_s),
    .dividend (sel_sum_s),
    .divisor  (sel_cnt_s),
    .busy     (div_busy_s),
    .done     (div_done_s),
    .quotient (div_q_s)
  );

  assign mem_rd_en   = rd_en_r;
  assign mem_rd_addr = rd_addr_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign converged   = converged_r;
  assign iterations  = iter_r;
  assign centroids   = cent_r;

endmodule

// File: tb/tb_kmeans_kn_engine.sv
// Directed bench for kmeans_kn_engine: three configurations share one
// point memory and run hand-computed clustering cases.
module tb_kmeans_kn_engine;

  localparam int DW = 16;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [DW-1:0] mem_d0 [0:255];
  logic [DW-1:0] mem_d1 [0:255];

  int checks = 0;
  int errors = 0;

  // Instance a: K=2, MAX_ITER=16
  logic          start_a;
  logic [AW:0]   npts_a;
  logic [63:0]   init_a, cent_a;
  logic          rd_en_a, busy_a, done_a, conv_a;
  logic [AW-1:0] rd_addr_a;
  logic [DW-1:0] rd_d0_a, rd_d1_a;
  logic [4:0]    iter_a;

  // Instance b: K=4, MAX_ITER=16
  logic          start_b;
  logic [AW:0]   npts_b;
  logic [127:0]  init_b, cent_b;
  logic          rd_en_b, busy_b, done_b, conv_b;
  logic [AW-1:0] rd_addr_b;
  logic [DW-1:0] rd_d0_b, rd_d1_b;
  logic [4:0]    iter_b;

  // Instance c: K=2, MAX_ITER=1
  logic          start_c;
  logic [AW:0]   npts_c;
  logic [63:0]   init_c, cent_c;
  logic          rd_en_c, busy_c, done_c, conv_c;
  logic [AW-1:0] rd_addr_c;
  logic [DW-1:0] rd_d0_c, rd_d1_c;
  logic [0:0]    iter_c;

  kmeans_kn_engine #(.K(2), .DW(DW), .AW(AW), .MAX_ITER(16), .ITW(5)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .n_points(npts_a), .cent_init(init_a),
    .mem_rd_en(rd_en_a), .mem_rd_addr(rd_addr_a), .mem_rd_d0(rd_d0_a), .mem_rd_d1(rd_d1_a),
    .busy(busy_a), .done(done_a), .converged(conv_a), .iterations(iter_a), .centroids(cent_a));

  kmeans_kn_engine #(.K(4), .DW(DW), .AW(AW), .MAX_ITER(16), .ITW(5)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .n_points(npts_b), .cent_init(init_b),
    .mem_rd_en(rd_en_b), .mem_rd_addr(rd_addr_b), .mem_rd_d0(rd_d0_b), .mem_rd_d1(rd_d1_b),
    .busy(busy_b), .done(done_b), .converged(conv_b), .iterations(iter_b), .centroids(cent_b));

  kmeans_kn_engine #(.K(2), .DW(DW), .AW(AW), .MAX_ITER(1), .ITW(1)) u_dut_c (
    .clk(clk), .rst(rst), .start(start_c), .n_points(npts_c), .cent_init(init_c),
    .mem_rd_en(rd_en_c), .mem_rd_addr(rd_addr_c), .mem_rd_d0(rd_d0_c), .mem_rd_d1(rd_d1_c),
    .busy(busy_c), .done(done_c), .converged(conv_c), .iterations(iter_c), .centroids(cent_c));

  // 1-cycle-latency memory ports
  always @(posedge clk) begin
    if (rd_en_a) begin rd_d0_a <= mem_d0[rd_addr_a]; rd_d1_a <= mem_d1[rd_addr_a]; end
    if (rd_en_b) begin rd_d0_b <= mem_d0[rd_addr_b]; rd_d1_b <= mem_d1[rd_addr_b]; end
    if (rd_en_c) begin rd_d0_c <= mem_d0[rd_addr_c]; rd_d1_c <= mem_d1[rd_addr_c]; end
  end

  // Event counters for instance a
  int rd_cnt_a = 0;
  int done_cnt_a = 0;
  always @(posedge clk) begin
    if (rd_en_a) rd_cnt_a <= rd_cnt_a + 1;
    if (done_a) done_cnt_a <= done_cnt_a + 1;
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(input int which, input string tag);
    int  n = 0;
    logic seen = 1'b0;
    while (!seen && n < 5000) begin
      @(negedge clk);
      n++;
      case (which)
        0:       seen = done_a;
        1:       seen = done_b;
        default: seen = done_c;
      endcase
    end
    check_eq({tag, "_done_seen"}, seen, 1'b1);
  endtask

  task automatic load_pt(input int idx, input int x, input int y);
    mem_d0[idx] = DW'(x);
    mem_d1[idx] = DW'(y);
  endtask

  task automatic load_four();
    load_pt(0, 0, 0); load_pt(1, 1, 1); load_pt(2, 10, 10); load_pt(3, 11, 11);
  endtask

  task automatic start_run_a(input int n, input logic [63:0] init);
    @(negedge clk);
    npts_a = (AW+1)'(n); init_a = init; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; npts_a = '0; init_a = '0;
    start_b = 1'b0; npts_b = '0; init_b = '0;
    start_c = 1'b0; npts_c = '0; init_c = '0;
    for (int i = 0; i < 256; i++) begin mem_d0[i] = '0; mem_d1[i] = '0; end
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_busy", busy_a, 1'b0);
    check_eq("rst_done", done_a, 1'b0);
    check_eq("rst_rd_en", rd_en_a, 1'b0);
    check_eq("rst_cent", cent_a, 64'd0);
    check_eq("rst_iter", iter_a, 5'd0);
    rst = 1'b0;

    // Two well separated pairs
    load_four();
    start_run_a(4, {16'd11, 16'd11, 16'd0, 16'd0});
    check_eq("t1_busy", busy_a, 1'b1);
    wait_done(0, "t1");
    check_eq("t1_conv", conv_a, 1'b1);
    check_eq("t1_iter", iter_a, 5'd2);
    check_eq("t1_cent", cent_a, {16'd10, 16'd10, 16'd0, 16'd0});
    @(negedge clk);
    check_eq("t1_busy_after", busy_a, 1'b0);
    check_eq("t1_done_pulse", done_a, 1'b0);

    // Equidistant point goes to the lower index
    load_pt(0, 5, 5);
    start_run_a(1, {16'd6, 16'd6, 16'd4, 16'd4});
    wait_done(0, "tie");
    check_eq("tie_conv", conv_a, 1'b1);
    check_eq("tie_iter", iter_a, 5'd2);
    check_eq("tie_cent", cent_a, {16'd6, 16'd6, 16'd5, 16'd5});

    // Empty run: no reads, centroids untouched
    begin
      int r0;
      r0 = rd_cnt_a;
      start_run_a(0, {16'd300, 16'd200, 16'd9, 16'd7});
      wait_done(0, "n0");
      check_eq("n0_conv", conv_a, 1'b1);
      check_eq("n0_iter", iter_a, 5'd1);
      check_eq("n0_cent", cent_a, {16'd300, 16'd200, 16'd9, 16'd7});
      check_eq("n0_reads", 128'(rd_cnt_a - r0), 128'd0);
    end

    // Empty clusters keep their centroids (K=4)
    for (int i = 0; i < 8; i++) load_pt(i, 3, 3);
    @(negedge clk);
    npts_b = 9'd8;
    init_b = {16'd100, 16'd100, 16'd100, 16'd100, 16'd100, 16'd100, 16'd3, 16'd3};
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    wait_done(1, "empty");
    check_eq("empty_conv", conv_b, 1'b1);
    check_eq("empty_iter", iter_b, 5'd1);
    check_eq("empty_cent", cent_b, {16'd100, 16'd100, 16'd100, 16'd100, 16'd100, 16'd100, 16'd3, 16'd3});

    // Iteration limit reached before convergence (MAX_ITER=1)
    load_four();
    @(negedge clk);
    npts_c = 9'd4;
    init_c = {16'd11, 16'd11, 16'd0, 16'd0};
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    wait_done(2, "lim");
    check_eq("lim_conv", conv_c, 1'b0);
    check_eq("lim_iter", iter_c, 1'b1);
    check_eq("lim_cent", cent_c, {16'd10, 16'd10, 16'd0, 16'd0});

    // Reset in the middle of streaming
    begin
      int n = 0;
      int dc;
      start_run_a(4, {16'd11, 16'd11, 16'd0, 16'd0});
      while (!rd_en_a && n < 100) begin @(negedge clk); n++; end
      check_eq("mid_in_stream", rd_en_a, 1'b1);
      dc = done_cnt_a;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_eq("mid_busy", busy_a, 1'b0);
      check_eq("mid_done", done_a, 1'b0);
      check_eq("mid_conv", conv_a, 1'b0);
      check_eq("mid_rd_en", rd_en_a, 1'b0);
      check_eq("mid_addr", rd_addr_a, 8'd0);
      check_eq("mid_iter", iter_a, 5'd0);
      check_eq("mid_cent", cent_a, 64'd0);
      repeat (60) @(negedge clk);
      check_eq("mid_no_done", 128'(done_cnt_a - dc), 128'd0);
    end

    // Start pulsed while busy must be ignored
    start_run_a(4, {16'd11, 16'd11, 16'd0, 16'd0});
    repeat (8) @(negedge clk);
    npts_a = 9'd1; init_a = {16'd60, 16'd60, 16'd50, 16'd50}; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done(0, "ign");
    check_eq("ign_conv", conv_a, 1'b1);
    check_eq("ign_iter", iter_a, 5'd2);
    check_eq("ign_cent", cent_a, {16'd10, 16'd10, 16'd0, 16'd0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
